aznable_timer: RTL and testbench

Parametrised multi-channel millisecond timer for the Aznable 8-bit system: a memory-mapped CPU peripheral decoded in the timer window. It replaces the single fixed 16-bit free-running millisecond counter. It adds per-channel prescaled counters, tear-free multi-byte reads, compare match with auto-clear, and an active-low interrupt request suitable for the Z80 `int_n`.

---
 rtl/aznable_timer.sv | 183 ++++++++++++++++++
 tb/tb_aznable_timer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aznable_timer.sv
// rtl/aznable_timer.sv - multi-channel prescaled millisecond timer peripheral
//
// Purpose: CHANNELS independent counters, each advanced once every DIVIDER
// clk_sys cycles. Multi-byte counter reads are tear-free via a snapshot that
// a low-byte read captures. Optional compare/match/interrupt logic is
// compiled in when the macro AZNABLE_TIMER_IRQ_EN is defined.
//
// Ports:
//   clk_sys  system clock, rising edge
//   reset_n  asynchronous active-low reset
//   cs       timer window select
//   wr_n     CPU write strobe, active low, level-sensitive
//   rd_n     CPU read strobe, active low, level-sensitive
//   addr     {channel[2:0], reg[2:0]}
//   din      CPU write data
//   dout     CPU read data, combinational, 0 when cs=0
//   int_n    registered interrupt request, active low
module aznable_timer #(
  parameter int CHANNELS = 2,
  parameter int WIDTH    = 16,
  parameter int DIVIDER  = 24000
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       cs,
  input  logic       wr_n,
  input  logic       rd_n,
  input  logic [5:0] addr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       int_n
);

  localparam int            PW       = $clog2(DIVIDER);
  localparam logic [PW-1:0] PRE_LAST = PW'(DIVIDER - 1);

  logic [2:0] ch_sel;
  logic [2:0] reg_sel;
  logic       wr_cyc;
  logic       rd_cyc;

  assign ch_sel  = addr[5:3];
  assign reg_sel = addr[2:0];
  assign wr_cyc  = cs & ~wr_n;
  assign rd_cyc  = cs & ~rd_n;

  logic [CHANNELS*8-1:0] rd_flat;

`ifdef AZNABLE_TIMER_IRQ_EN
  logic [CHANNELS-1:0] irq_vec;
`else
  logic unused_din;
  assign unused_din = ^din[7:1];
`endif

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic             hit;
    logic             wr_hit;
    logic             cnt_clr;
    logic             tick;
    logic             wrap_to_zero;
    logic [PW-1:0]    pre;
    logic [WIDTH-1:0] cnt;
    logic [15:0]      snap;
    logic             en;
    logic [7:0]       ctrl_rd;
    logic [7:0]       cmp_lo_rd;
    logic [7:0]       cmp_hi_rd;
    logic [7:0]       rd_byte;

    assign hit     = (ch_sel == 3'(i));
    assign wr_hit  = wr_cyc & hit;
    assign cnt_clr = wr_hit & ((reg_sel == 3'd0) | (reg_sel == 3'd1));
    assign tick    = en & (pre == PRE_LAST);

    // A counter write restarts the prescaler so the first tick after a clear
    // lands exactly DIVIDER cycles after the write's last cycle.
    always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n)     pre <= '0;
      else if (cnt_clr) pre <= '0;
      else if (en)      pre <= tick ? '0 : pre + 1'b1;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n)     cnt <= '0;
      else if (cnt_clr) cnt <= '0;
      else if (tick)    cnt <= wrap_to_zero ? '0 : cnt + 1'b1;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n)                            en <= 1'b1;
      else if (wr_hit && reg_sel == 3'd4)      en <= din[0];
    end

    // Captured on every low-byte read cycle so a following high-byte read
    // returns the same 16-bit value even if a carry happened in between.
    always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n)                              snap <= '0;
      else if (rd_cyc && hit && reg_sel == 3'd0) snap <= 16'(cnt);
    end

`ifdef AZNABLE_TIMER_IRQ_EN
    logic [WIDTH-1:0] cmp;
    logic [15:0]      cmp_ext;
    logic             autoclr;
    logic             irqen;
    logic             match;
    logic             match_now;

    assign cmp_ext = 16'(cmp);
    // A counter write in the same cycle suppresses the match; a cmp write in
    // the same cycle does not matter because the old cmp is compared here.
    assign match_now    = tick & ~cnt_clr & (cnt == cmp);
    assign wrap_to_zero = match_now & autoclr;

    always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n)                        cmp <= '1;
      else if (wr_hit && reg_sel == 3'd2)  cmp <= WIDTH'({cmp_ext[15:8], din});
      else if (wr_hit && reg_sel == 3'd3)  cmp <= WIDTH'({din, cmp_ext[7:0]});
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
        autoclr <= 1'b0;
        irqen   <= 1'b0;
        match   <= 1'b0;
      end else begin
        if (wr_hit && reg_sel == 3'd4) begin
          autoclr <= din[1];
          irqen   <= din[2];
        end
        // Setting wins over a simultaneous write-one-to-clear.
        if (match_now)                                  match <= 1'b1;
        else if (wr_hit && reg_sel == 3'd4 && din[7])   match <= 1'b0;
      end
    end

    assign ctrl_rd    = {match, 4'b0000, irqen, autoclr, en};
    assign cmp_lo_rd  = cmp_ext[7:0];
    assign cmp_hi_rd  = cmp_ext[15:8];
    assign irq_vec[i] = match & irqen;
`else
    assign wrap_to_zero = 1'b0;
    assign ctrl_rd      = {7'b0000000, en};
    assign cmp_lo_rd    = 8'h00;
    assign cmp_hi_rd    = 8'h00;
`endif

    always_comb begin
      rd_byte = 8'h00;
      case (reg_sel)
        3'd0:    rd_byte = 8'(cnt);
        3'd1:    rd_byte = snap[15:8];
        3'd2:    rd_byte = cmp_lo_rd;
        3'd3:    rd_byte = cmp_hi_rd;
        3'd4:    rd_byte = ctrl_rd;
        default: rd_byte = 8'h00;
      endcase
    end

    assign rd_flat[i*8 +: 8] = rd_byte;
  end

  // Channels at or above CHANNELS never match and therefore read 0.
  always_comb begin
    dout = 8'h00;
    if (cs) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (ch_sel == 3'(i)) dout = rd_flat[i*8 +: 8];
      end
    end
  end

`ifdef AZNABLE_TIMER_IRQ_EN
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) int_n <= 1'b1;
    else          int_n <= ~(|irq_vec);
  end
`else
  assign int_n = 1'b1;
`endif

endmodule

// File: tb/tb_aznable_timer.sv
// tb/tb_aznable_timer.sv - self-checking bench for aznable_timer
module tb_aznable_timer;

  localparam int DIV = 4;
`ifdef AZNABLE_TIMER_IRQ_EN
  localparam bit IRQ = 1'b1;
`else
  localparam bit IRQ = 1'b0;
`endif
  localparam logic [7:0] CMP_RST = IRQ ? 8'hFF : 8'h00;

  logic       clk_sys = 1'b0;
  logic       reset_n = 1'b0;
  logic       cs      = 1'b0;
  logic       wr_n    = 1'b1;
  logic       rd_n    = 1'b1;
  logic [5:0] addr    = 6'd0;
  logic [7:0] din     = 8'd0;
  logic [7:0] dout16;
  logic [7:0] dout8;
  logic       int_n16;
  logic       int_n8;

  always #5 clk_sys = ~clk_sys;

  aznable_timer #(.CHANNELS(2), .WIDTH(16), .DIVIDER(DIV)) u_dut16 (
    .clk_sys(clk_sys), .reset_n(reset_n), .cs(cs), .wr_n(wr_n), .rd_n(rd_n),
    .addr(addr), .din(din), .dout(dout16), .int_n(int_n16)
  );

  aznable_timer #(.CHANNELS(2), .WIDTH(8), .DIVIDER(DIV)) u_dut8 (
    .clk_sys(clk_sys), .reset_n(reset_n), .cs(cs), .wr_n(wr_n), .rd_n(rd_n),
    .addr(addr), .din(din), .dout(dout8), .int_n(int_n8)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: index [instance][channel]; instance 0 is 16-bit, 1 is 8-bit.
  int m_pre [2][2];
  int m_cnt [2][2];
  int m_cmp [2][2];
  int m_snap[2][2];
  int m_en  [2][2];
  int m_ac  [2][2];
  int m_ie  [2][2];
  int m_mt  [2][2];
  int m_intn[2];

  logic [7:0] s_dout[2];
  logic       s_int [2];

  typedef struct {
    logic       c_s;
    logic [5:0] a;
    logic [7:0] e16;
    logic [7:0] e8;
    string      name;
  } vec_t;

  vec_t tbl[$];

  function automatic int wdt(int m);
    return (m == 0) ? 16 : 8;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int c = 0; c < 2; c++) begin
        m_pre[m][c] = 0;  m_cnt[m][c] = 0;  m_snap[m][c] = 0;
        m_cmp[m][c] = (1 << wdt(m)) - 1;
        m_en[m][c] = 1;   m_ac[m][c] = 0;   m_ie[m][c] = 0;  m_mt[m][c] = 0;
      end
      m_intn[m] = 1;
    end
  endfunction

  function automatic int model_read(input int m, input logic c_s, input logic [5:0] a);
    int ch = int'(a[5:3]);
    int rg = int'(a[2:0]);
    if (!c_s || ch >= 2) return 0;
    case (rg)
      0: return m_cnt[m][ch] % 256;
      1: return (m_snap[m][ch] / 256) % 256;
      2: return IRQ ? m_cmp[m][ch] % 256 : 0;
      3: return IRQ ? (m_cmp[m][ch] / 256) % 256 : 0;
      4: return IRQ ? (m_mt[m][ch] * 128 + m_ie[m][ch] * 4 + m_ac[m][ch] * 2 + m_en[m][ch])
                    : m_en[m][ch];
      default: return 0;
    endcase
  endfunction

  function automatic void model_step(input logic c_s, input logic w_n, input logic r_n,
                                     input logic [5:0] a, input logic [7:0] d);
    int rg = int'(a[2:0]);
    for (int m = 0; m < 2; m++) begin
      int irq_any = 0;
      int modv = 1 << wdt(m);
      for (int c = 0; c < 2; c++)
        if (m_mt[m][c] != 0 && m_ie[m][c] != 0) irq_any = 1;
      m_intn[m] = (irq_any != 0) ? 0 : 1;
      for (int c = 0; c < 2; c++) begin
        bit hit    = c_s && (int'(a[5:3]) == c);
        bit wr     = hit && !w_n;
        bit rd     = hit && !r_n;
        bit clr    = wr && (rg < 2);
        bit tick   = (m_en[m][c] != 0) && (m_pre[m][c] == DIV - 1);
        bit hitcmp = IRQ && tick && !clr && (m_cnt[m][c] == m_cmp[m][c]);
        if (rd && rg == 0) m_snap[m][c] = m_cnt[m][c];
        if (clr) begin
          m_cnt[m][c] = 0;
          m_pre[m][c] = 0;
        end else begin
          if (m_en[m][c] != 0) m_pre[m][c] = (m_pre[m][c] + 1) % DIV;
          if (tick) m_cnt[m][c] = (hitcmp && m_ac[m][c] != 0) ? 0 : (m_cnt[m][c] + 1) % modv;
        end
        if (IRQ && wr && rg == 2) m_cmp[m][c] = ((m_cmp[m][c] / 256) * 256 + int'(d)) % modv;
        if (IRQ && wr && rg == 3) m_cmp[m][c] = (int'(d) * 256 + m_cmp[m][c] % 256) % modv;
        if (wr && rg == 4) begin
          m_en[m][c] = int'(d[0]);
          if (IRQ) begin
            m_ac[m][c] = int'(d[1]);
            m_ie[m][c] = int'(d[2]);
          end
        end
        if (hitcmp) m_mt[m][c] = 1;
        else if (IRQ && wr && rg == 4 && d[7]) m_mt[m][c] = 0;
      end
    end
  endfunction

  // One bus cycle: drive at the falling edge, sample 1 ns later, advance the
  // model across the coming rising edge, then wait for the next falling edge.
  task automatic cyc(input logic c_s, input logic w_n, input logic r_n,
                     input logic [5:0] a, input logic [7:0] d);
    cs = c_s; wr_n = w_n; rd_n = r_n; addr = a; din = d;
    #1;
    if (!reset_n) model_reset();
    s_dout[0] = dout16;  s_dout[1] = dout8;
    s_int[0]  = int_n16; s_int[1]  = int_n8;
    check("bus16",  int'(dout16),  model_read(0, c_s, a));
    check("bus8",   int'(dout8),   model_read(1, c_s, a));
    check("intn16", int'(int_n16), m_intn[0]);
    check("intn8",  int'(int_n8),  m_intn[1]);
    if (reset_n) model_step(c_s, w_n, r_n, a, d);
    @(negedge clk_sys);
  endtask

  task automatic rd(input logic [5:0] a);
    cyc(1'b1, 1'b1, 1'b0, a, 8'h00);
  endtask

  task automatic wr(input logic [5:0] a, input logic [7:0] d);
    cyc(1'b1, 1'b0, 1'b1, a, d);
  endtask

  initial begin
    tbl.push_back('{1'b1, 6'o04, 8'h01,   8'h01,   "rst_ctrl0"});
    tbl.push_back('{1'b1, 6'o14, 8'h01,   8'h01,   "rst_ctrl1"});
    tbl.push_back('{1'b1, 6'o02, CMP_RST, CMP_RST, "rst_cmplo"});
    tbl.push_back('{1'b1, 6'o03, CMP_RST, 8'h00,   "rst_cmphi"});
    tbl.push_back('{1'b1, 6'o12, CMP_RST, CMP_RST, "rst_cmplo1"});
    tbl.push_back('{1'b1, 6'o00, 8'h00,   8'h00,   "rst_cnt"});
    tbl.push_back('{1'b1, 6'o01, 8'h00,   8'h00,   "rst_snap"});
    tbl.push_back('{1'b1, 6'o05, 8'h00,   8'h00,   "rst_reg5"});
    tbl.push_back('{1'b1, 6'o17, 8'h00,   8'h00,   "rst_reg7"});
    tbl.push_back('{1'b1, 6'o34, 8'h00,   8'h00,   "rst_ch3"});
    tbl.push_back('{1'b0, 6'o04, 8'h00,   8'h00,   "rst_cs0"});

    @(negedge clk_sys);
    reset_n = 1'b0;
    cyc(1'b0, 1'b1, 1'b1, 6'o00, 8'h00);
    cyc(1'b0, 1'b1, 1'b1, 6'o00, 8'h00);
    foreach (tbl[i]) begin
      cyc(tbl[i].c_s, 1'b1, 1'b0, tbl[i].a, 8'h00);
      check({tbl[i].name, "_16"}, int'(s_dout[0]), int'(tbl[i].e16));
      check({tbl[i].name, "_8"},  int'(s_dout[1]), int'(tbl[i].e8));
    end
    check("rst_intn", int'(s_int[0]), 1);

    // Free-running count from reset, then the low-byte carry snapshot case.
    reset_n = 1'b1;
    for (int k = 0; k <= 1026; k++) begin
      rd((k == 1024 || k == 1026) ? 6'o01 : 6'o00);
      if (k <= 12)   check("cnt_start", int'(s_dout[0]), k / 4);
      if (k == 1023) begin
        check("pre_carry16", int'(s_dout[0]), 8'hFF);
        check("pre_wrap8",   int'(s_dout[1]), 8'hFF);
      end
      if (k == 1024) begin
        check("snap_hi16", int'(s_dout[0]), 8'h00);
        check("snap_hi8",  int'(s_dout[1]), 8'h00);
      end
      if (k == 1025) check("wrap8", int'(s_dout[1]), 8'h00);
      if (k == 1026) begin
        check("snap_hi16b", int'(s_dout[0]), 8'h01);
        check("intn_idle",  int'(s_int[1]), 1);
      end
    end

`ifdef AZNABLE_TIMER_IRQ_EN
    // Mid-operation reset, then compare/autoclear/interrupt sequence.
    reset_n = 1'b0;
    rd(6'o00);
    check("mid_reset", int'(s_dout[0]), 0);
    reset_n = 1'b1;
    wr(6'o02, 8'h03);
    wr(6'o03, 8'h00);
    wr(6'o04, 8'h07);
    wr(6'o00, 8'h00);
    for (int t = 0; t <= 36; t++) begin
      if (t == 17)      wr(6'o04, 8'h87);
      else if (t == 31) wr(6'o00, 8'h00);
      else if (t == 16 || t == 18 || t == 32) rd(6'o04);
      else              rd(6'o00);
      if (t < 16) check("ac_seq", int'(s_dout[0]), t / 4);
      if (t == 16) begin
        check("match_set",  int'(s_dout[0]), 8'h87);
        check("intn_lag",   int'(s_int[0]), 1);
      end
      if (t == 17) check("intn_fall", int'(s_int[0]), 0);
      if (t == 18) begin
        check("match_clr",  int'(s_dout[0]), 8'h07);
        check("intn_hold",  int'(s_int[0]), 0);
      end
      if (t == 19) begin
        check("intn_rise",  int'(s_int[0]), 1);
        check("ac_zero",    int'(s_dout[0]), 0);
      end
      if (t == 32) check("clr_beats_match", int'(s_dout[0]), 8'h07);
      if (t == 33) check("clr_no_irq",      int'(s_int[0]), 1);
      if (t == 35) check("clr_phase0",      int'(s_dout[0]), 0);
      if (t == 36) check("clr_phase1",      int'(s_dout[0]), 1);
    end
`endif

    // Disable holds cnt and pre; re-enable resumes from the held phase.
    wr(6'o00, 8'h00);
    for (int t = 0; t <= 25; t++) begin
      if (t == 2)       wr(6'o04, 8'h00);
      else if (t == 23) wr(6'o04, 8'h01);
      else              rd(6'o00);
      if (t == 22) check("frozen",     int'(s_dout[0]), 0);
      if (t == 24) check("resume_pre", int'(s_dout[0]), 0);
      if (t == 25) check("resume_inc", int'(s_dout[0]), 1);
    end

    // Nonexistent channel 3: reads 0, writes change nothing.
    wr(6'o30, 8'h55);
    wr(6'o34, 8'h00);
    rd(6'o34);
    check("ch3_ctrl", int'(s_dout[0]), 0);
    rd(6'o32);
    check("ch3_cmp", int'(s_dout[0]), 0);
    rd(6'o04);
    check("ch3_noeffect", int'(s_dout[0]), 8'h01);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      logic       c_s;
      logic       w_n;
      logic       r_n;
      logic [5:0] a;
      logic [7:0] d;
      c_s = ($urandom_range(0, 3) != 0);
      w_n = ($urandom_range(0, 9) != 0);
      r_n = 1'($urandom_range(0, 1));
      a   = {3'($urandom_range(0, 3)), 3'($urandom_range(0, 7))};
      d   = 8'($urandom);
      if (a[2:0] == 3'd2) d = 8'($urandom_range(0, 7));
      if (a[2:0] == 3'd3 && $urandom_range(0, 3) != 0) d = 8'h00;
      if (a[2:0] == 3'd4 && $urandom_range(0, 3) != 0) d[0] = 1'b1;
      if (n == 1500) reset_n = 1'b0;
      cyc(c_s, w_n, r_n, a, d);
      reset_n = 1'b1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
